// File: rtl/md_sched.sv
// md_sched: multiply/divide sequencer. Latches an E-stage op, counts a fixed latency, then commits HI/LO.
// Define MD_ABORT_EN to add the `abort` input that discards an in-flight op.
module md_sched #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10,
  parameter int CNT_W       = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  md_op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        d_md_use,
`ifdef MD_ABORT_EN
  input  logic        abort,
`endif
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [31:0] md_rdata,
  output logic        busy,
  output logic        stall
);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTLO  = 4'd5;
  localparam logic [3:0] OP_MTHI  = 4'd6;
  localparam logic [3:0] OP_MFLO  = 4'd7;
  localparam logic [3:0] OP_MFHI  = 4'd8;

  localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES);
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [3:0]         op_p1;
  logic [31:0]        a_p1, b_p1;
  logic               abort_w, accept, last;
  logic signed [63:0] sprod;
  logic [63:0]        uprod;
  logic [31:0]        res_hi, res_lo;
  logic               res_we;

`ifdef MD_ABORT_EN
  assign abort_w = abort;
`else
  assign abort_w = 1'b0;
`endif

  // Signed divide via magnitudes: quotient truncates toward zero, remainder takes the dividend's sign.
  // 0x80000000 / -1 falls out as quotient 0x80000000, remainder 0.
  function automatic logic [63:0] div_signed(input logic [31:0] x, input logic [31:0] y);
    logic [31:0] ux, uy, q, r;
    ux = x[31] ? (~x + 32'd1) : x;
    uy = y[31] ? (~y + 32'd1) : y;
    q  = ux / uy;
    r  = ux % uy;
    if (x[31] ^ y[31]) q = ~q + 32'd1;
    if (x[31])         r = ~r + 32'd1;
    return {r, q};
  endfunction

  function automatic logic [63:0] div_unsigned(input logic [31:0] x, input logic [31:0] y);
    return {x % y, x / y};
  endfunction

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    last    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start && !abort_w && md_op >= OP_MULT && md_op <= OP_DIVU) begin
          accept  = 1'b1;
          state_d = BUSY;
          cnt_d   = (md_op >= OP_DIV) ? DIV_LOAD : MULT_LOAD;
        end
      end
      BUSY: begin
        if (abort_w) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - 1'b1;
          if (cnt_q == CNT_W'(1)) begin
            last    = 1'b1;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Result of the latched op; a zero divisor leaves HI/LO untouched.
  always_comb begin
    sprod  = $signed({{32{a_p1[31]}}, a_p1}) * $signed({{32{b_p1[31]}}, b_p1});
    uprod  = {32'd0, a_p1} * {32'd0, b_p1};
    res_hi = hi;
    res_lo = lo;
    res_we = 1'b0;
    case (op_p1)
      OP_MULT:  begin res_we = 1'b1; {res_hi, res_lo} = sprod; end
      OP_MULTU: begin res_we = 1'b1; {res_hi, res_lo} = uprod; end
      OP_DIV: begin
        res_we = (b_p1 != 32'd0);
        {res_hi, res_lo} = div_signed(a_p1, b_p1);
      end
      OP_DIVU: begin
        res_we = (b_p1 != 32'd0);
        {res_hi, res_lo} = div_unsigned(a_p1, b_p1);
      end
      default: res_we = 1'b0;
    endcase
  end

  // p1: operands latched at accept; HI/LO written at commit or by mthi/mtlo.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_p1 <= '0;
      a_p1  <= '0;
      b_p1  <= '0;
      hi    <= '0;
      lo    <= '0;
    end else begin
      if (accept) begin
        op_p1 <= md_op;
        a_p1  <= a;
        b_p1  <= b;
      end
      if (last && res_we) begin
        hi <= res_hi;
        lo <= res_lo;
      end else if (state_q == IDLE && !start) begin
        if (md_op == OP_MTHI) hi <= a;
        if (md_op == OP_MTLO) lo <= a;
      end
    end
  end

  assign busy  = (state_q == BUSY);
  assign stall = (start | busy) & d_md_use;

  always_comb begin
    md_rdata = 32'd0;
    if (md_op == OP_MFHI) md_rdata = hi;
    else if (md_op == OP_MFLO) md_rdata = lo;
  end

endmodule
